// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with load, tc lookahead and registered wrap pulse; q 1 clock, tc 0 clocks.
// No backpressure. Optional registered Gray output q_gray when MOD_UPDOWN_COUNTER_GRAY_OUT_EN is defined.

module mud_dff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) q <= RST_VAL;
    else       q <= d;
  end
endmodule

module mud_tff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic t,
  output logic q
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset)  q <= RST_VAL;
    else if (t) q <= ~q;
  end
endmodule

module mod_updown_counter #(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 10,
  parameter int INIT        = 0,
  parameter     REALIZATION = "d-type"
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
`ifdef MOD_UPDOWN_COUNTER_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] q_gray
`endif
);

  localparam logic [WIDTH-1:0] TOP    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MODULUS);
  localparam bit               USE_T  = (REALIZATION == "t-type");

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             at_top;
  logic             at_zero;

  assign at_top  = (q == TOP);
  assign at_zero = (q == '0);

  // Wrap is decided by comparison against the modulus ends, not by carry out.
  always @* begin
    q_next    = q;
    wrap_next = 1'b0;
    if (load) begin
      q_next = ({1'b0, load_val} >= MOD_X) ? TOP : load_val;
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          q_next    = '0;
          wrap_next = 1'b1;
        end else begin
          q_next = q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          q_next    = TOP;
          wrap_next = 1'b1;
        end else begin
          q_next = q - WIDTH'(1);
        end
      end
    end
  end

  assign tc = en & ~load & (up ? at_top : at_zero);

  // Unknown REALIZATION strings fall back to D flops.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (USE_T) begin : g_t
      mud_tff #(.RST_VAL(INIT_V[i])) u_ff (
        .clock (clock),
        .reset (reset),
        .t     (q[i] ^ q_next[i]),
        .q     (q[i])
      );
    end else begin : g_d
      mud_dff #(.RST_VAL(INIT_V[i])) u_ff (
        .clock (clock),
        .reset (reset),
        .d     (q_next[i]),
        .q     (q[i])
      );
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) wrap <= 1'b0;
    else       wrap <= wrap_next;
  end

`ifdef MOD_UPDOWN_COUNTER_GRAY_OUT_EN
  // Encoded from q_next so the Gray value lands on the same edge as q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) q_gray <= INIT_V ^ (INIT_V >> 1);
    else       q_gray <= q_next ^ (q_next >> 1);
  end
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: d-type and t-type instances driven in parallel.
// Covers MOD_UPDOWN_COUNTER_GRAY_OUT_EN when the macro is defined.

module tb_mod_updown_counter;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] lv;
  logic [3:0] qd, qt;
  logic       tcd, tct, wd, wt;
`ifdef MOD_UPDOWN_COUNTER_GRAY_OUT_EN
  logic [3:0] gd, gt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .INIT(0), .REALIZATION("d-type")) u_d (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (lv),
    .q        (qd),
    .tc       (tcd),
    .wrap     (wd)
`ifdef MOD_UPDOWN_COUNTER_GRAY_OUT_EN
    ,
    .q_gray   (gd)
`endif
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .INIT(0), .REALIZATION("t-type")) u_t (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (lv),
    .q        (qt),
    .tc       (tct),
    .wrap     (wt)
`ifdef MOD_UPDOWN_COUNTER_GRAY_OUT_EN
    ,
    .q_gray   (gt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [3:0] exp);
    chk({tag, ".q_d"}, 32'(qd), 32'(exp));
    chk({tag, ".q_t"}, 32'(qt), 32'(exp));
  endtask

  task automatic chk_w(input string tag, input logic exp);
    chk({tag, ".wrap_d"}, 32'(wd), 32'(exp));
    chk({tag, ".wrap_t"}, 32'(wt), 32'(exp));
  endtask

  task automatic chk_tc(input string tag, input logic exp);
    chk({tag, ".tc_d"}, 32'(tcd), 32'(exp));
    chk({tag, ".tc_t"}, 32'(tct), 32'(exp));
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  logic [3:0] up_seq  [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
  logic       dir_seq [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0] dir_exp [4]  = '{4'd5, 4'd4, 4'd5, 4'd4};

  initial begin
    logic [3:0] prev;
    logic [3:0] m;
    logic       wm;
    logic       tcm;

    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lv = 4'd0;
    #3;
    chk_q("rst", 4'd0);
    chk_w("rst", 1'b0);
    chk_tc("rst", 1'b0);
    #10 reset = 1'b0;
    tick;

    // Up count through the wrap
    en = 1'b1; up = 1'b1; prev = 4'd0;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk_tc("up", prev == 4'd9);
      tick;
      chk_q("up", up_seq[i]);
      chk_w("up", up_seq[i] == 4'd0);
      prev = up_seq[i];
    end

    // Down count from zero
    load = 1'b1; lv = 4'd0;
    tick;
    load = 1'b0; up = 1'b0;
    #1 chk_tc("dn0", 1'b1);
    tick;
    chk_q("dn9", 4'd9);
    chk_w("dn9", 1'b1);
    chk_tc("dn9", 1'b0);
    tick;
    chk_q("dn8", 4'd8);
    chk_w("dn8", 1'b0);
    tick;
    chk_q("dn7", 4'd7);

    // Load, clamp, and tc masked by load
    load = 1'b1; en = 1'b1; up = 1'b1; lv = 4'd6;
    #1 chk_tc("ld6", 1'b0);
    tick;
    chk_q("ld6", 4'd6);
    chk_w("ld6", 1'b0);
    lv = 4'd13;
    #1 chk_tc("ld13", 1'b0);
    tick;
    chk_q("ld13", 4'd9);
    chk_w("ld13", 1'b0);
    #1 chk_tc("ld_at9", 1'b0);
    tick;
    chk_q("ld_at9", 4'd9);
    chk_w("ld_at9", 1'b0);

    // Hold and direction change
    lv = 4'd4;
    tick;
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk_tc("hold", 1'b0);
      tick;
      chk_q("hold", 4'd4);
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up = dir_seq[i];
      tick;
      chk_q("dir", dir_exp[i]);
    end

    // Asynchronous reset between edges
    load = 1'b1; lv = 4'd7; en = 1'b0;
    tick;
    load = 1'b0;
    chk_q("pre_rst", 4'd7);
    #2 reset = 1'b1;
    #1;
    chk_q("async_rst", 4'd0);
    chk_w("async_rst", 1'b0);
`ifdef MOD_UPDOWN_COUNTER_GRAY_OUT_EN
    chk("async_rst.gray_d", 32'(gd), 32'd0);
    chk("async_rst.gray_t", 32'(gt), 32'd0);
`endif
    #2 reset = 1'b0;
    en = 1'b1; up = 1'b1;
    tick;
    chk_q("post_rst", 4'd1);

    load = 1'b1; lv = 4'd9;
    tick;
    load = 1'b0;
    tick;
    chk_q("wrap_pre_rst", 4'd0);
    chk_w("wrap_pre_rst", 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_w("wrap_rst", 1'b0);
    chk_q("wrap_rst", 4'd0);
    #2 reset = 1'b0;
    en = 1'b0;

`ifdef MOD_UPDOWN_COUNTER_GRAY_OUT_EN
    load = 1'b1; lv = 4'd5;
    tick;
    chk("gray5_d", 32'(gd), 32'd7);
    chk("gray5_t", 32'(gt), 32'd7);
    lv = 4'd9;
    tick;
    chk("gray9_d", 32'(gd), 32'd13);
    chk("gray9_t", 32'(gt), 32'd13);
    load = 1'b0;
`endif

    // Random cycles: both realizations against each other and a reference model
    load = 1'b1; lv = 4'd3;
    tick;
    m = 4'd3; wm = 1'b0;
    for (int i = 0; i < 200; i++) begin
      en   = 1'($urandom_range(0, 1));
      up   = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 7) == 0);
      lv   = 4'($urandom_range(0, 15));
      tcm  = en & ~load & (up ? (m == 4'd9) : (m == 4'd0));
      #1 chk_tc("rnd", tcm);
      wm = 1'b0;
      if (load) m = (lv >= 4'd10) ? 4'd9 : lv;
      else if (en && up) begin
        if (m == 4'd9) begin m = 4'd0; wm = 1'b1; end
        else m = m + 4'd1;
      end else if (en) begin
        if (m == 4'd0) begin m = 4'd9; wm = 1'b1; end
        else m = m - 4'd1;
      end
      tick;
      chk("rnd.q_eq", 32'(qt), 32'(qd));
      chk_q("rnd", m);
      chk_w("rnd", wm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
